// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with start/busy handshake tracking and an acknowledge watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       SampleClk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [NUM_REQ*DATA_W-1:0]  ReqData,
    output logic [NUM_REQ-1:0]         ReqReady,
    output logic                       TxStart,
    output logic [DATA_W-1:0]          TxData,
    input  logic                       TxBusy,
    output logic [$clog2(NUM_REQ)-1:0] GrantId,
    output logic                       ArbBusy,
    output logic                       TimeoutErr,
    output logic [7:0]                 ErrCount
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(ACK_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state_r;
    logic [PTR_W-1:0]      ptr_r;
    logic [WD_W-1:0]       wd_r;
    logic                  tx_start_r;
    logic [NUM_REQ-1:0]    req_ready_r;
    logic [DATA_W-1:0]     tx_data_r;
    logic [PTR_W-1:0]      grant_id_r;
    logic                  arb_busy_r;
    logic                  timeout_err_r;
    logic [7:0]            err_count_r;

    logic                  pick_found_s;
    logic [PTR_W-1:0]      pick_idx_s;
    logic [PTR_W-1:0]      ptr_next_s;
    logic [DATA_W-1:0]     pick_data_s;
    logic [NUM_REQ-1:0]    pick_onehot_s;
    logic [WD_W-1:0]       wd_next_s;

    // Scan downward so the surviving hit is the first set bit at or after ptr.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [PTR_W-1:0]   ptr);
        logic             found;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        idx   = {PTR_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Winner selection, captured byte, one-hot accept and watchdog increment
    always_comb begin
        pick_found_s  = 1'b0;
        pick_idx_s    = {PTR_W{1'b0}};
        pick_data_s   = {DATA_W{1'b0}};
        pick_onehot_s = {NUM_REQ{1'b0}};
        {pick_found_s, pick_idx_s} = rr_pick(ReqValid, ptr_r);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick_idx_s) begin
                pick_data_s      = ReqData[i*DATA_W +: DATA_W];
                pick_onehot_s[i] = 1'b1;
            end else begin
                pick_onehot_s[i] = 1'b0;
            end
        end
        if (pick_idx_s == LAST_IDX) begin
            ptr_next_s = {PTR_W{1'b0}};
        end else begin
            ptr_next_s = pick_idx_s + PTR_W'(1);
        end
        wd_next_s = wd_r + WD_W'(1);
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge SampleClk) begin
        if (Reset) begin
            state_r       <= IDLE;
            ptr_r         <= {PTR_W{1'b0}};
            wd_r          <= {WD_W{1'b0}};
            tx_start_r    <= 1'b0;
            req_ready_r   <= {NUM_REQ{1'b0}};
            tx_data_r     <= {DATA_W{1'b0}};
            grant_id_r    <= {PTR_W{1'b0}};
            arb_busy_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            tx_start_r    <= 1'b0;
            req_ready_r   <= {NUM_REQ{1'b0}};
            timeout_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        tx_data_r   <= pick_data_s;
                        grant_id_r  <= pick_idx_s;
                        ptr_r       <= ptr_next_s;
                        tx_start_r  <= 1'b1;
                        req_ready_r <= pick_onehot_s;
                        arb_busy_r  <= 1'b1;
                        state_r     <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    wd_r    <= {WD_W{1'b0}};
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A stale busy from an earlier frame also counts as the acknowledge.
                    if (TxBusy) begin
                        state_r <= WAIT_DONE;
                    end else if (wd_next_s == WD_LAST) begin
                        wd_r          <= wd_next_s;
                        timeout_err_r <= 1'b1;
                        if (err_count_r != 8'hFF) begin
                            err_count_r <= err_count_r + 8'd1;
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        arb_busy_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        wd_r <= wd_next_s;
                    end
                end
                WAIT_DONE: begin
                    if (!TxBusy) begin
                        arb_busy_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                default: begin
                    arb_busy_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign ReqReady   = req_ready_r;
    assign TxStart    = tx_start_r;
    assign TxData     = tx_data_r;
    assign GrantId    = grant_id_r;
    assign ArbBusy    = arb_busy_r;
    assign TimeoutErr = timeout_err_r;
    assign ErrCount   = err_count_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: grant timing, round-robin order,
// pointer wrap, watchdog with counter saturation, reset mid-frame and request withdrawal.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 16;

    logic                       SampleClk = 1'b0;
    logic                       Reset;
    logic [NUM_REQ-1:0]         ReqValid;
    logic [NUM_REQ*DATA_W-1:0]  ReqData;
    logic [NUM_REQ-1:0]         ReqReady;
    logic                       TxStart;
    logic [DATA_W-1:0]          TxData;
    logic                       TxBusy;
    logic [1:0]                 GrantId;
    logic                       ArbBusy;
    logic                       TimeoutErr;
    logic [7:0]                 ErrCount;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .SampleClk(SampleClk), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqReady(ReqReady), .TxStart(TxStart), .TxData(TxData), .TxBusy(TxBusy),
        .GrantId(GrantId), .ArbBusy(ArbBusy), .TimeoutErr(TimeoutErr), .ErrCount(ErrCount)
    );

    always #5 SampleClk = ~SampleClk;

    // Waits up to budget cycles for a start pulse; cycles = negedges until it was seen.
    task automatic wait_start(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge SampleClk);
            cycles++;
            if (TxStart === 1'b1) seen = 1'b1;
        end
    endtask

    // Transmitter model: busy from the cycle after TxStart for len cycles.
    task automatic tx_frame(input int len);
        @(negedge SampleClk);
        TxBusy = 1'b1;
        repeat (len) @(negedge SampleClk);
        TxBusy = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ReqValid = 4'b0000; ReqData = 32'h0; TxBusy = 1'b0;
        repeat (3) @(negedge SampleClk);
        n_checks++;
        if ({TxStart, ReqReady, TxData, GrantId, ArbBusy, TimeoutErr, ErrCount} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {TxStart, ReqReady, TxData, GrantId, ArbBusy, TimeoutErr, ErrCount});
        end
        n_checks++;
        if (dut.ptr_r !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d required 0", dut.ptr_r); end
        Reset = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit seen; int bad;
        ReqValid = 4'b0100; ReqData[2*DATA_W +: DATA_W] = 8'hA5;
        wait_start(20, cyc, seen);
        n_checks++;
        if (!seen || cyc !== 1) begin n_fail++; $display("FAIL single_latency: got seen=%0d cycles=%0d required 1", seen, cyc); end
        n_checks++;
        if ({ReqReady, TxData, GrantId, ArbBusy} !== {4'b0100, 8'hA5, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: ready=%b data=%h id=%0d busy=%b required 0100 a5 2 1", ReqReady, TxData, GrantId, ArbBusy);
        end
        ReqValid = 4'b0000;
        @(negedge SampleClk);
        n_checks++;
        if ({TxStart, ReqReady} !== 5'd0) begin n_fail++; $display("FAIL single_pulse_width: got %b required 00000", {TxStart, ReqReady}); end
        @(negedge SampleClk);
        TxBusy = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SampleClk);
            if (ArbBusy !== 1'b1 || TimeoutErr !== 1'b0 || TxData !== 8'hA5) bad++;
        end
        TxBusy = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL single_busy_hold: got %0d bad cycles required 0", bad); end
        @(negedge SampleClk);
        n_checks++;
        if (ArbBusy !== 1'b0 || dut.ptr_r !== 2'd3) begin
            n_fail++; $display("FAIL single_release: arbbusy=%b ptr=%0d required 0 3", ArbBusy, dut.ptr_r);
        end
    endtask

    task automatic test_round_robin();
        int cyc; bit seen; logic [1:0] exp_id; logic [7:0] exp_d; logic [3:0] exp_rdy;
        Reset = 1'b1;
        @(negedge SampleClk);
        Reset = 1'b0;
        ReqValid = 4'b1111; ReqData = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int g = 0; g < 6; g++) begin
            wait_start(40, cyc, seen);
            exp_id  = 2'(g % 4);
            exp_d   = 8'h10 + 8'(g % 4);
            exp_rdy = 4'b0001 << exp_id;
            n_checks++;
            if (!seen || {GrantId, TxData, ReqReady} !== {exp_id, exp_d, exp_rdy}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: id=%0d data=%h ready=%b required %0d %h %b", g, GrantId, TxData, ReqReady, exp_id, exp_d, exp_rdy);
            end
            if (g > 0) begin
                n_checks++;
                if (cyc !== 2) begin n_fail++; $display("FAIL rr_back_to_back%0d: got %0d cycles required 2", g, cyc); end
            end
            if (g == 5) ReqValid = 4'b0000;
            tx_frame(3);
        end
    endtask

    task automatic test_pointer_wrap();
        int cyc; bit seen;
        ReqValid = 4'b0100; ReqData = {8'h03, 8'h22, 8'h31, 8'h30};
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || GrantId !== 2'd2) begin n_fail++; $display("FAIL wrap_setup: id=%0d required 2", GrantId); end
        tx_frame(2);
        n_checks++;
        if (dut.ptr_r !== 2'd3) begin n_fail++; $display("FAIL wrap_ptr: got %0d required 3", dut.ptr_r); end
        ReqValid = 4'b0011;
        wait_start(40, cyc, seen);
        n_checks++;
        if (!seen || GrantId !== 2'd0 || TxData !== 8'h30) begin n_fail++; $display("FAIL wrap_first: id=%0d data=%h required 0 30", GrantId, TxData); end
        tx_frame(2);
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || GrantId !== 2'd1 || TxData !== 8'h31) begin n_fail++; $display("FAIL wrap_second: id=%0d data=%h required 1 31", GrantId, TxData); end
        tx_frame(2);
    endtask

    task automatic test_watchdog();
        int cyc; bit seen; int c; int n_to;
        ReqValid = 4'b0010; ReqData[1*DATA_W +: DATA_W] = 8'h5A;
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || GrantId !== 2'd1) begin n_fail++; $display("FAIL wd_grant: id=%0d required 1", GrantId); end
        c = 0;
        while (TimeoutErr !== 1'b1 && c < 40) begin @(negedge SampleClk); c++; end
        n_checks++;
        if (c !== ACK_TIMEOUT) begin n_fail++; $display("FAIL wd_latency: got %0d cycles required %0d", c, ACK_TIMEOUT); end
        n_checks++;
        if (ErrCount !== 8'd1 || ArbBusy !== 1'b0) begin n_fail++; $display("FAIL wd_count: errcount=%0d arbbusy=%b required 1 0", ErrCount, ArbBusy); end
        @(negedge SampleClk);
        n_checks++;
        if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_width: got %b required 0", TimeoutErr); end
        ReqValid = 4'b0010; ReqData[1*DATA_W +: DATA_W] = 8'h6B;
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || GrantId !== 2'd1 || TxData !== 8'h6B) begin n_fail++; $display("FAIL wd_recover: id=%0d data=%h required 1 6b", GrantId, TxData); end
        tx_frame(2);
        n_to = 0;
        for (int r = 0; r < 299; r++) begin
            ReqValid = 4'b0010;
            wait_start(40, cyc, seen);
            ReqValid = 4'b0000;
            c = 0;
            while (TimeoutErr !== 1'b1 && c < 40) begin @(negedge SampleClk); c++; end
            if (seen && TimeoutErr === 1'b1) n_to++;
        end
        n_checks++;
        if (n_to !== 299) begin n_fail++; $display("FAIL wd_repeat: got %0d timeouts required 299", n_to); end
        n_checks++;
        if (ErrCount !== 8'd255) begin n_fail++; $display("FAIL wd_saturate: got %0d required 255", ErrCount); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc; bit seen;
        ReqValid = 4'b0001; ReqData[0 +: DATA_W] = 8'h77;
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        @(negedge SampleClk);
        TxBusy = 1'b1;
        @(negedge SampleClk);
        n_checks++;
        if (ArbBusy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight: arbbusy=%b required 1", ArbBusy); end
        Reset = 1'b1;
        @(negedge SampleClk);
        Reset = 1'b0;
        TxBusy = 1'b0;
        n_checks++;
        if ({TxStart, ReqReady, TxData, GrantId, ArbBusy, TimeoutErr, ErrCount} !== 25'd0 || dut.ptr_r !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h ptr=%0d required 0 0", {TxStart, ReqReady, TxData, GrantId, ArbBusy, TimeoutErr, ErrCount}, dut.ptr_r);
        end
        ReqValid = 4'b1000; ReqData[3*DATA_W +: DATA_W] = 8'hC3;
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || cyc !== 1 || {GrantId, TxData, ReqReady} !== {2'd3, 8'hC3, 4'b1000}) begin
            n_fail++;
            $display("FAIL rst_mid_regrant: cycles=%0d id=%0d data=%h ready=%b required 1 3 c3 1000", cyc, GrantId, TxData, ReqReady);
        end
        tx_frame(2);
    endtask

    task automatic test_withdrawal();
        int cyc; bit seen; int starts; int ready1;
        ReqValid = 4'b0001; ReqData[0 +: DATA_W] = 8'h44;
        wait_start(40, cyc, seen);
        ReqValid = 4'b0000;
        n_checks++;
        if (!seen || GrantId !== 2'd0) begin n_fail++; $display("FAIL wdraw_grant: id=%0d required 0", GrantId); end
        @(negedge SampleClk);
        TxBusy = 1'b1;
        repeat (2) @(negedge SampleClk);
        ReqValid = 4'b0010;
        starts = 0; ready1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge SampleClk);
            if (TxStart === 1'b1) starts++;
            if (ReqReady[1] === 1'b1) ready1++;
            if (i == 0) ReqValid = 4'b0000;
            if (i == 3) TxBusy = 1'b0;
        end
        n_checks++;
        if (starts !== 0) begin n_fail++; $display("FAIL wdraw_start: got %0d extra starts required 0", starts); end
        n_checks++;
        if (ready1 !== 0) begin n_fail++; $display("FAIL wdraw_ready: got %0d ready pulses required 0", ready1); end
        n_checks++;
        if (ArbBusy !== 1'b0) begin n_fail++; $display("FAIL wdraw_idle: arbbusy=%b required 0", ArbBusy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_watchdog();
        test_reset_mid_frame();
        test_withdrawal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish within 1000000 time units");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters, e.g. a loopback echo from the receiver, a status reporter and a debug port.
- Arbitration is round-robin. The block captures the winning byte, issues a one-cycle start pulse to the transmitter and tracks the transmitter's busy signal until the frame completes.
- A watchdog flags a transmitter that never acknowledges a start pulse.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- DATA_W, 8: byte width.
- ACK_TIMEOUT, 16: cycles allowed after TxStart for TxBusy to rise; minimum 2.

Ports:
- SampleClk  in  1  system clock, all logic on posedge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  NUM_REQ  bit i: requester i has a byte pending.
- ReqData  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- ReqReady  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- TxStart  out  1  one-cycle start pulse to the transmitter.
- TxData  out  DATA_W  byte to the transmitter, held stable from TxStart until the return to IDLE.
- TxBusy  in  1  transmitter frame in progress.
- GrantId  out  clog2(NUM_REQ)  index of the current or last granted requester.
- ArbBusy  out  1  high in every state except IDLE.
- TimeoutErr  out  1  one-cycle pulse on a watchdog expiry.
- ErrCount  out  8  saturating count of timeouts.

Behaviour:
- Reset: the following are applied while Reset=1 at a clock edge, regardless of state:
  - state=IDLE, Ptr=0, TxStart=0, ReqReady=0, TxData=0, GrantId=0, ArbBusy=0, TimeoutErr=0, ErrCount=0, watchdog count=0.
  - A frame already in flight in the transmitter is abandoned and not tracked.
- Requester rule: ReqData[i] is stable while ReqValid[i]=1 until ReqReady[i] pulses. Dropping ReqValid before a grant is legal; the byte is then simply not sent.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any ReqValid bit is set, select the first set index scanning Ptr, Ptr+1, ... with wrap modulo NUM_REQ.
  - Register TxData=ReqData[sel] and GrantId=sel. Set Ptr=(sel+1) mod NUM_REQ.
  - Go to START.
  - If no ReqValid bit is set, stay in IDLE; Ptr is unchanged.
- START, exactly 1 cycle:
  - TxStart=1 and ReqReady[GrantId]=1 (registered outputs, asserted in this cycle only).
  - Clear the watchdog and go to WAIT_BUSY.
- WAIT_BUSY:
  - TxBusy=1: go to WAIT_DONE.
  - Otherwise increment the watchdog.
  - When the watchdog reaches ACK_TIMEOUT-1 with TxBusy still 0: pulse TimeoutErr for 1 cycle, ErrCount+1 (saturates at 255), go to IDLE. The byte is dropped and not retried.
- WAIT_DONE: stay while TxBusy=1; go to IDLE on the first cycle TxBusy=0.
- Latency:
  - Request sampled in IDLE at cycle t gives TxStart and ReqReady at t+1.
  - After TxBusy falls at cycle u, the block is back in IDLE at u+1, and the earliest next TxStart is u+2.
- Simultaneous events:
  - A requester that re-asserts ReqValid in the same cycle it receives ReqReady is treated as a new byte.
  - Round-robin guarantees every active requester is served within NUM_REQ grants.
- TxBusy already high before TxStart (a stale frame) still counts as the acknowledge. The transmitter is required not to be busy when the arbiter is in IDLE.
- ReqValid and ReqData are ignored outside IDLE.

Test Plan:
- Single requester: after reset, ReqValid=4'b0100, ReqData[2]=8'hA5; TxBusy rises 2 cycles after TxStart and stays high 20 cycles. Required: TxStart and ReqReady=4'b0100 one cycle after the request, TxData=8'hA5, GrantId=2, ArbBusy high until the cycle after TxBusy falls, then Ptr=3.
- Round-robin fairness: all four requesters hold ReqValid with bytes 8'h10, 8'h11, 8'h12, 8'h13 and re-assert after each ReqReady. Required: grant order 0,1,2,3,0,1 and TxData sequence 10,11,12,13,10,11.
- Pointer wrap: Ptr=3 after a grant to 2, then only requesters 0 and 1 valid. Required: grant 0 next, then 1.
- Watchdog: grant requester 1 with TxBusy tied 0. Required: TimeoutErr pulse exactly ACK_TIMEOUT cycles after TxStart, ErrCount=1, return to IDLE, next request served normally. Repeat 300 times; ErrCount saturates at 255.
- Reset mid-frame: assert Reset for 1 cycle while in WAIT_DONE. Required: all outputs at reset values next cycle, Ptr=0; a request from requester 3 after reset is granted normally with GrantId=3.
- Request withdrawal: ReqValid[1] pulses for 1 cycle while the arbiter is in WAIT_DONE. Required: no ReqReady[1] and no extra TxStart.
